// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs a signed immediate into I/S/B/J instruction fields
//
// Purpose:
//   Inverse of the decode-side immediate extender. Takes a 32-bit signed immediate,
//   places its bits into the I/S/B/J immediate positions of an instruction word and
//   merges them with a base word whose immediate bits are cleared first. Two register
//   stages (S1 check, S2 pack) with valid/ready handshakes on both sides.
//
// Ports:
//   clk         in   1        clock, all state updates on the rising edge
//   reset       in   1        synchronous active-high reset
//   in_valid    in   1        request valid
//   in_ready    out  1        request can be accepted this cycle
//   immsrc      in   2        00 I-type, 01 S-type, 10 B-type, 11 J-type
//   immval      in   32       signed immediate (byte offset for B/J)
//   base        in   32       instruction word, immediate bits ignored
//   out_valid   out  1        instr/err valid
//   out_ready   in   1        downstream accepts instr
//   instr       out  32       encoded instruction
//   err         out  1        immediate out of range or misaligned
//   word_count  out  COUNT_W  output handshakes since reset, wraps
//   err_count   out  COUNT_W  output handshakes with err=1, saturates
//
// Configuration:
//   IMM_ENCODER_RANGE_CHECK_EN  when defined, range/alignment checking drives err and
//   err_count and an erroneous word carries a zero immediate field. When undefined,
//   err and err_count are tied to zero and out-of-range values are truncated.

module imm_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         immsrc,
  input  logic [31:0]        immval,
  input  logic [31:0]        base,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic               err,
  output logic [COUNT_W-1:0] word_count,
  output logic [COUNT_W-1:0] err_count
);

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;
  localparam logic [1:0] SRC_J = 2'b11;

  // Immediate bit positions per format; these bits of base are always cleared.
  localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
  localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
  localparam logic [31:0] MASK_J  = 32'hFFFF_F000;

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  // S1 (check) stage
  logic        s1_valid;
  logic [1:0]  s1_immsrc;
  logic [31:0] s1_immval;
  logic [31:0] s1_base;

  // Handshake / flow control
  logic s2_loads;
  logic in_fire;
  logic out_fire;

  // Packing datapath
  logic [31:0] pack_mask;
  logic [31:0] pack_field;
  logic        pack_err;
  logic [31:0] pack_instr;

  assign out_fire = out_valid & out_ready;
  // S2 takes a new word whenever it is empty or its word leaves this cycle.
  assign s2_loads = s1_valid & (~out_valid | out_ready);
  // Purely a function of pipeline state so upstream may wait on in_ready.
  assign in_ready = ~s1_valid | s2_loads;
  assign in_fire  = in_valid & in_ready;

  // ------------------------------------------------------------------
  // S1: accept request
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_immsrc <= SRC_I;
      s1_immval <= '0;
      s1_base   <= '0;
    end else if (in_fire) begin
      s1_immsrc <= immsrc;
      s1_immval <= immval;
      s1_base   <= base;
    end
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  // A value fits an N-bit signed field when every bit from N-1 up to 31 equals
  // the sign, so the range test reduces to all-ones/all-zeros of the upper slice.
  logic fits12;
  logic fits13;
  logic fits21;
  logic in_bad;
  logic s1_bad;

  assign fits12 = (&immval[31:11]) | ~(|immval[31:11]);
  assign fits13 = (&immval[31:12]) | ~(|immval[31:12]);
  assign fits21 = (&immval[31:20]) | ~(|immval[31:20]);

  always_comb begin
    in_bad = 1'b0;
    case (immsrc)
      SRC_I,
      SRC_S:   in_bad = ~fits12;
      SRC_B:   in_bad = ~fits13 | immval[0];
      default: in_bad = ~fits21 | immval[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_bad <= 1'b0;
    end else if (in_fire) begin
      s1_bad <= in_bad;
    end
  end

  assign pack_err = s1_bad;
`else
  // Upper immediate bits only feed the range check, which is absent here.
  logic unused_imm_hi;
  assign unused_imm_hi = ^s1_immval[31:21];
  assign pack_err      = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Pack: scatter immediate bits into the format's field positions
  // ------------------------------------------------------------------
  always_comb begin
    pack_mask  = MASK_I;
    pack_field = '0;
    case (s1_immsrc)
      SRC_S: begin
        pack_mask  = MASK_SB;
        pack_field = {s1_immval[11:5], 13'b0, s1_immval[4:0], 7'b0};
      end
      SRC_B: begin
        pack_mask  = MASK_SB;
        pack_field = {s1_immval[12], s1_immval[10:5], 13'b0,
                      s1_immval[4:1], s1_immval[11], 7'b0};
      end
      SRC_J: begin
        pack_mask  = MASK_J;
        pack_field = {s1_immval[20], s1_immval[10:1], s1_immval[11],
                      s1_immval[19:12], 12'b0};
      end
      default: begin
        pack_mask  = MASK_I;
        pack_field = {s1_immval[11:0], 20'b0};
      end
    endcase
    // A rejected immediate leaves only the masked base behind.
    pack_instr = (s1_base & ~pack_mask) | (pack_err ? 32'h0 : pack_field);
  end

  // ------------------------------------------------------------------
  // S2: output register, held while stalled
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= '0;
    end else begin
      if (~out_valid | out_ready) begin
        out_valid <= s1_valid;
      end
      if (s2_loads) begin
        instr <= pack_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_count <= '0;
    end else if (out_fire) begin
      word_count <= word_count + CNT_ONE;
    end
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (s2_loads) begin
      err <= pack_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (out_fire && err && !(&err_count)) begin
      err_count <= err_count + CNT_ONE;
    end
  end
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder against an arithmetic model

module tb_imm_encoder;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  immsrc = 2'b00;
  logic [31:0] immval = '0;
  logic [31:0] base = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        err;
  logic [15:0] word_count;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;

  imm_encoder #(.COUNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .immsrc     (immsrc),
    .immval     (immval),
    .base       (base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .err        (err),
    .word_count (word_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Field bits computed with shifts and masks straight from the packing table.
  function automatic logic [31:0] model_field(input logic [1:0] s, input logic [31:0] v);
    case (s)
      2'd0: return (v & 32'hFFF) << 20;
      2'd1: return (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
      2'd2: return (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) |
                   (((v >> 1) & 32'hF) << 8)   | (((v >> 11) & 32'h1) << 7);
      default: return (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21) |
                      (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12);
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] s, input logic [31:0] v);
    int sv;
    sv = $signed(v);
    if (!RC_EN) return 1'b0;
    case (s)
      2'd0, 2'd1: return (sv < -2048) || (sv > 2047);
      2'd2:       return (sv < -4096) || (sv > 4094) || (v[0] == 1'b1);
      default:    return (sv < -(1 << 20)) || (sv > (1 << 20) - 2) || (v[0] == 1'b1);
    endcase
  endfunction

  function automatic logic [31:0] model_instr(input logic [1:0] s, input logic [31:0] v,
                                              input logic [31:0] b);
    logic [31:0] m;
    m = model_field(s, 32'hFFFF_FFFF);
    return (b & ~m) | (model_err(s, v) ? 32'h0 : model_field(s, v));
  endfunction

  function automatic logic [31:0] gen_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r = {{20{r[11]}}, r[11:0]};
      1: r = {{19{r[12]}}, r[12:0]};
      2: r = {{11{r[20]}}, r[20:0]};
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) r[0] = 1'b0;
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One isolated request; returns the word seen and cycles from accept to out_valid.
  task automatic run_single(input logic [1:0] s, input logic [31:0] v, input logic [31:0] b,
                            output logic [31:0] oi, output logic oe, output int lat);
    int guard;
    @(posedge clk); #1;
    immsrc = s; immval = v; base = b; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0; immsrc = 2'($urandom); immval = $urandom; base = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    oi = instr; oe = err;
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [1:0]  vs[6];
    logic [31:0] vv[6], vb[6], ve[6];
    logic        vee[6];
    logic [31:0] oi;
    logic        oe;
    int          lat;
    vs[0] = 2'd0; vv[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0013; ve[0] = 32'hFFF0_0013; vee[0] = 1'b0;
    vs[1] = 2'd1; vv[1] = 32'hFFFF_FFFC; vb[1] = 32'h0000_2023; ve[1] = 32'hFE00_2E23; vee[1] = 1'b0;
    vs[2] = 2'd2; vv[2] = 32'h0000_0800; vb[2] = 32'h0000_0063; ve[2] = 32'h0000_00E3; vee[2] = 1'b0;
    vs[3] = 2'd3; vv[3] = 32'h0000_0002; vb[3] = 32'h0000_006F; ve[3] = 32'h0020_006F; vee[3] = 1'b0;
    vs[4] = 2'd0; vv[4] = 32'h0000_0800; vb[4] = 32'hFFF0_0013;
    ve[4] = RC_EN ? 32'h0000_0013 : 32'h8000_0013; vee[4] = RC_EN;
    vs[5] = 2'd2; vv[5] = 32'h0000_0003; vb[5] = 32'h0000_0063;
    ve[5] = RC_EN ? 32'h0000_0063 : 32'h0000_0163; vee[5] = RC_EN;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      run_single(vs[i], vv[i], vb[i], oi, oe, lat);
      checks++; if (oi !== ve[i]) begin errors++; $display("FAIL vector%0d_instr: got %h expected %h", i, oi, ve[i]); end
      checks++; if (oe !== vee[i]) begin errors++; $display("FAIL vector%0d_err: got %b expected %b", i, oe, vee[i]); end
      checks++; if (lat != 2) begin errors++; $display("FAIL vector%0d_latency: got %0d expected 2", i, lat); end
    end
    @(negedge clk);
    checks++; if (word_count !== 16'd6) begin errors++; $display("FAIL vectors_word_count: got %0d expected 6", word_count); end
    checks++; if (err_count !== (RC_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL vectors_err_count: got %0d expected %0d", err_count, RC_EN ? 2 : 0); end
  endtask

  task automatic test_range();
    logic [1:0]  rs[16];
    logic [31:0] rv[16];
    logic [31:0] rb, oi;
    logic        oe;
    int          lat, nerr;
    rs[0]  = 2'd0; rv[0]  = -32'sd2048;   rs[1]  = 2'd0; rv[1]  = 32'd2047;
    rs[2]  = 2'd0; rv[2]  = -32'sd2049;   rs[3]  = 2'd1; rv[3]  = 32'd2048;
    rs[4]  = 2'd1; rv[4]  = -32'sd2048;   rs[5]  = 2'd1; rv[5]  = 32'd2047;
    rs[6]  = 2'd2; rv[6]  = 32'd4094;     rs[7]  = 2'd2; rv[7]  = -32'sd4096;
    rs[8]  = 2'd2; rv[8]  = 32'd4096;     rs[9]  = 2'd2; rv[9]  = -32'sd4098;
    rs[10] = 2'd3; rv[10] = 32'h000F_FFFE; rs[11] = 2'd3; rv[11] = 32'hFFF0_0000;
    rs[12] = 2'd3; rv[12] = 32'h0010_0000; rs[13] = 2'd3; rv[13] = 32'h0000_0001;
    rs[14] = 2'd3; rv[14] = 32'hFFEF_FFFE; rs[15] = 2'd1; rv[15] = 32'h8000_0000;
    reset_dut();
    nerr = 0;
    for (int i = 0; i < 16; i++) begin
      rb = $urandom;
      run_single(rs[i], rv[i], rb, oi, oe, lat);
      if (model_err(rs[i], rv[i])) nerr++;
      checks++; if (oi !== model_instr(rs[i], rv[i], rb)) begin errors++; $display("FAIL range%0d_instr: got %h expected %h", i, oi, model_instr(rs[i], rv[i], rb)); end
      checks++; if (oe !== model_err(rs[i], rv[i])) begin errors++; $display("FAIL range%0d_err: got %b expected %b", i, oe, model_err(rs[i], rv[i])); end
    end
    @(negedge clk);
    checks++; if (word_count !== 16'd16) begin errors++; $display("FAIL range_word_count: got %0d expected 16", word_count); end
    checks++; if (err_count !== 16'(nerr)) begin errors++; $display("FAIL range_err_count: got %0d expected %0d", err_count, nerr); end
  endtask

  task automatic test_backpressure();
    logic [1:0]  rs[4];
    logic [31:0] rv[4], rb[4];
    logic [31:0] eq_i[$];
    logic        eq_e[$];
    logic [31:0] held;
    logic        last_in_ready;
    int          idx, acc, got, cyc;
    for (int i = 0; i < 4; i++) begin
      rs[i] = 2'($urandom_range(0, 3)); rv[i] = gen_imm(); rb[i] = $urandom;
    end
    held = model_instr(rs[0], rv[0], rb[0]);
    reset_dut();
    idx = 0; acc = 0; got = 0; last_in_ready = 1'b1;
    immsrc = rs[0]; immval = rv[0]; base = rb[0]; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      last_in_ready = in_ready;
      if (in_valid && in_ready) begin
        eq_i.push_back(model_instr(rs[idx], rv[idx], rb[idx]));
        eq_e.push_back(model_err(rs[idx], rv[idx]));
        acc++; idx++;
      end
      if (out_valid) begin
        checks++; if (instr !== held) begin errors++; $display("FAIL bp_hold_cycle%0d: got %h expected %h", c, instr, held); end
      end
      @(posedge clk); #1;
      if (idx < 4) begin immsrc = rs[idx]; immval = rv[idx]; base = rb[idx]; end
      else in_valid = 1'b0;
    end
    checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
    checks++; if (last_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", last_in_ready); end
    out_ready = 1'b1;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        eq_i.push_back(model_instr(rs[idx], rv[idx], rb[idx]));
        eq_e.push_back(model_err(rs[idx], rv[idx]));
        idx++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (eq_i.size() == 0) begin errors++; $display("FAIL bp_spurious: got %h expected no word", instr); end
        else begin
          if (instr !== eq_i[0] || err !== eq_e[0]) begin errors++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", got, instr, err, eq_i[0], eq_e[0]); end
          void'(eq_i.pop_front()); void'(eq_e.pop_front());
        end
        got++;
      end
      @(posedge clk); #1; cyc++;
      if (idx < 4) begin immsrc = rs[idx]; immval = rv[idx]; base = rb[idx]; end
      else in_valid = 1'b0;
    end
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (got != 4) begin errors++; $display("FAIL bp_drained: got %0d expected 4", got); end
    checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL bp_word_count: got %0d expected 4", word_count); end
  endtask

  // mode 0: continuous valid/ready; mode 1: random valid and random out_ready
  task automatic test_streaming(input int n, input int mode);
    logic [1:0]  rs[256];
    logic [31:0] rv[256], rb[256];
    logic [31:0] eq_i[$];
    logic        eq_e[$];
    int          idx, got, cyc, first_out, last_out, nerr, bad;
    for (int i = 0; i < n; i++) begin
      rs[i] = 2'($urandom_range(0, 3)); rv[i] = gen_imm(); rb[i] = $urandom;
    end
    reset_dut();
    idx = 0; got = 0; cyc = 0; first_out = -1; last_out = -1; nerr = 0; bad = 0;
    immsrc = rs[0]; immval = rv[0]; base = rb[0];
    in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        eq_i.push_back(model_instr(rs[idx], rv[idx], rb[idx]));
        eq_e.push_back(model_err(rs[idx], rv[idx]));
        if (model_err(rs[idx], rv[idx])) nerr++;
        idx++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        checks++;
        if (eq_i.size() == 0) begin errors++; bad++; $display("FAIL stream%0d_spurious: got %h expected no word", mode, instr); end
        else begin
          if (instr !== eq_i[0] || err !== eq_e[0]) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL stream%0d_word%0d: got %h/%b expected %h/%b", mode, got, instr, err, eq_i[0], eq_e[0]);
          end
          void'(eq_i.pop_front()); void'(eq_e.pop_front());
        end
        got++;
      end
      @(posedge clk); #1; cyc++;
      if (idx < n) begin
        immsrc = rs[idx]; immval = rv[idx]; base = rb[idx];
        in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else in_valid = 1'b0;
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (got != n) begin errors++; $display("FAIL stream%0d_count: got %0d expected %0d", mode, got, n); end
    checks++; if (word_count !== 16'(n)) begin errors++; $display("FAIL stream%0d_word_count: got %0d expected %0d", mode, word_count, n); end
    checks++; if (err_count !== 16'(nerr)) begin errors++; $display("FAIL stream%0d_err_count: got %0d expected %0d", mode, err_count, nerr); end
    if (mode == 0) begin
      checks++; if (first_out != 2) begin errors++; $display("FAIL stream_first_out_cycle: got %0d expected 2", first_out); end
      checks++; if (last_out - first_out != n - 1) begin errors++; $display("FAIL stream_throughput: got span %0d expected %0d", last_out - first_out, n - 1); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [1:0]  s;
    logic [31:0] v, b, oi;
    logic        oe;
    int          lat, stale;
    reset_dut();
    immsrc = 2'd0; immval = 32'h0000_0123; base = 32'h0000_0013; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    immsrc = 2'd3; immval = 32'h0000_0456;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL mid_word_count: got %0d expected 0", word_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL mid_err_count: got %0d expected 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d stale words expected 0", stale); end
    s = 2'd1; v = 32'hFFFF_F800; b = 32'h0000_2023;
    run_single(s, v, b, oi, oe, lat);
    checks++; if (oi !== model_instr(s, v, b)) begin errors++; $display("FAIL mid_next_word: got %h expected %h", oi, model_instr(s, v, b)); end
    @(negedge clk);
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", word_count); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_range();
    test_backpressure();
    test_streaming(100, 0);
    test_streaming(200, 1);
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
